pcs_tx_sequencer: RTL and testbench

// 1000BASE-X PCS transmit ordered-set sequencer. It takes the GMII transmit interface and generates the

---
 rtl/pcs_tx_sequencer_if.sv | 29 ++
 rtl/pcs_tx_sequencer.sv | 151 +++++++++++++++
 tb/tb_pcs_tx_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pcs_tx_sequencer_if.sv
// GMII transmit side plus the 8b/10b encoder side of the 1000BASE-X PCS
// transmit sequencer, bundled so the sequencer and its driver share one bus.
interface pcs_tx_sequencer_if;
  // GMII transmit inputs and encoder feedback
  logic        tx_en;
  logic        tx_er;
  logic [7:0]  txd;
  logic        cfg_en;
  logic [15:0] cfg_word;
  logic        enc_rd;

  // Code-group stream towards the encoder
  logic [7:0]  enc_data;
  logic        enc_control;
  logic        tx_even;
  logic        sop_drop;

  // Side that drives GMII and observes the encoder stream
  modport master (
    output tx_en, tx_er, txd, cfg_en, cfg_word, enc_rd,
    input  enc_data, enc_control, tx_even, sop_drop
  );

  // Sequencer side
  modport slave (
    input  tx_en, tx_er, txd, cfg_en, cfg_word, enc_rd,
    output enc_data, enc_control, tx_even, sop_drop
  );
endinterface

// File: rtl/pcs_tx_sequencer.sv
// 1000BASE-X PCS transmit ordered-set sequencer. Turns the GMII transmit
// interface into one code-group (byte + K flag) per clock for the 8b/10b
// encoder: idles, frame delimiters, error symbols and auto-negotiation
// config ordered sets. Ordered sets and /S/ always land on even positions.
module pcs_tx_sequencer #(
  parameter bit R_ALIGN     = 1'b1,
  parameter bit CFG_SUPPORT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  pcs_tx_sequencer_if.slave  gmii
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef enum logic [2:0] {
    OS_START,
    IDLE_D,
    CFG_D,
    CFG_LO,
    CFG_HI,
    DATA,
    EOP_R,
    EOP_R2
  } state_t;

  state_t      state_q;
  logic [7:0]  enc_data_q;
  logic        enc_control_q;
  logic        tx_even_q;
  logic        sop_drop_q;
  logic [15:0] cfgWord_q;
  logic        cfgSel_q;

  logic        txEven_d;
  logic        cfgActive_d;

  // Position of the code-group being produced this cycle, and whether config
  // ordered sets are requested at all
  always_comb begin
    txEven_d    = ~tx_even_q;
    cfgActive_d = gmii.cfg_en & CFG_SUPPORT;
  end

  // Ordered-set sequencer; every output is registered so the encoder sees one
  // cycle of latency from GMII
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= OS_START;
      enc_data_q    <= 8'h00;
      enc_control_q <= 1'b0;
      tx_even_q     <= 1'b0;
      sop_drop_q    <= 1'b0;
      cfgWord_q     <= 16'h0000;
      cfgSel_q      <= 1'b0;
    end else begin
      tx_even_q  <= txEven_d;
      sop_drop_q <= 1'b0;
      case (state_q)
        OS_START: begin
          if (gmii.tx_en && !cfgActive_d) begin
            enc_data_q    <= K27_7;
            enc_control_q <= 1'b1;
            cfgSel_q      <= 1'b0;
            state_q       <= DATA;
          end else if (cfgActive_d) begin
            enc_data_q    <= K28_5;
            enc_control_q <= 1'b1;
            cfgWord_q     <= gmii.cfg_word;
            state_q       <= CFG_D;
          end else begin
            enc_data_q    <= K28_5;
            enc_control_q <= 1'b1;
            cfgSel_q      <= 1'b0;
            state_q       <= IDLE_D;
          end
        end
        IDLE_D: begin
          enc_data_q    <= gmii.enc_rd ? D5_6 : D16_2;
          enc_control_q <= 1'b0;
          sop_drop_q    <= gmii.tx_en;
          state_q       <= OS_START;
        end
        CFG_D: begin
          enc_data_q    <= cfgSel_q ? D2_2 : D21_5;
          enc_control_q <= 1'b0;
          cfgSel_q      <= ~cfgSel_q;
          state_q       <= CFG_LO;
        end
        CFG_LO: begin
          enc_data_q    <= cfgWord_q[7:0];
          enc_control_q <= 1'b0;
          state_q       <= CFG_HI;
        end
        CFG_HI: begin
          enc_data_q    <= cfgWord_q[15:8];
          enc_control_q <= 1'b0;
          state_q       <= OS_START;
        end
        DATA: begin
          if (gmii.tx_en) begin
            if (gmii.tx_er) begin
              enc_data_q    <= K30_7;
              enc_control_q <= 1'b1;
            end else begin
              enc_data_q    <= gmii.txd;
              enc_control_q <= 1'b0;
            end
          end else begin
            enc_data_q    <= K29_7;
            enc_control_q <= 1'b1;
            state_q       <= EOP_R;
          end
        end
        EOP_R: begin
          enc_data_q    <= K23_7;
          enc_control_q <= 1'b1;
          if (R_ALIGN && txEven_d) begin
            state_q <= EOP_R2;
          end else begin
            state_q <= OS_START;
          end
        end
        EOP_R2: begin
          enc_data_q    <= K23_7;
          enc_control_q <= 1'b1;
          state_q       <= OS_START;
        end
        default: begin
          enc_data_q    <= 8'h00;
          enc_control_q <= 1'b0;
          state_q       <= OS_START;
        end
      endcase
    end
  end

  assign gmii.enc_data    = enc_data_q;
  assign gmii.enc_control = enc_control_q;
  assign gmii.tx_even     = tx_even_q;
  assign gmii.sop_drop    = sop_drop_q;

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Bench for pcs_tx_sequencer: directed GMII vectors with hand-computed
// code-group expectations queued per cycle and checked by a separate monitor.
module tb_pcs_tx_sequencer;

  typedef struct packed {
    logic [15:0] stepNum;
    logic [7:0]  data;
    logic        ctrl;
    logic        even;
    logic        sop;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        curRd;
  logic [15:0] curCfgWord;
  int          stepCount;
  int          checkCount;
  int          failCount;
  exp_t        expQ[$];

  pcs_tx_sequencer_if bus ();

  pcs_tx_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .gmii  (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge and queue the code-group
  // expected after the next rising edge
  task automatic applyStimulus(input logic rst, input logic en, input logic er,
                               input logic [7:0] d, input logic cfg,
                               input logic [7:0] eData, input logic eCtrl,
                               input logic eEven, input logic eSop);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.tx_en    = en;
    bus.tx_er    = er;
    bus.txd      = d;
    bus.cfg_en   = cfg;
    bus.cfg_word = curCfgWord;
    bus.enc_rd   = curRd;
    stepCount++;
    e.stepNum = 16'(stepCount);
    e.data    = eData;
    e.ctrl    = eCtrl;
    e.even    = eEven;
    e.sop     = eSop;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (bus.enc_data !== e.data || bus.enc_control !== e.ctrl ||
        bus.tx_even !== e.even || bus.sop_drop !== e.sop) begin
      failCount++;
      $display("[TB] FAIL step%0d: got data=%h ctrl=%b even=%b sop=%b, expected data=%h ctrl=%b even=%b sop=%b",
               e.stepNum, bus.enc_data, bus.enc_control, bus.tx_even, bus.sop_drop,
               e.data, e.ctrl, e.even, e.sop);
    end
  endtask

  // Monitor: compare the DUT output against the oldest expectation each cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed stimulus
  initial begin
    logic [7:0] frameA [9];
    frameA = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02};
    stepCount    = 0;
    checkCount   = 0;
    failCount    = 0;
    curRd        = 1'b1;
    curCfgWord   = 16'h01A0;
    reset        = 1'b1;
    bus.tx_en    = 1'b0;
    bus.tx_er    = 1'b0;
    bus.txd      = 8'h00;
    bus.cfg_en   = 1'b0;
    bus.cfg_word = curCfgWord;
    bus.enc_rd   = curRd;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hC5, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hC5, 0, 0, 0);
    curRd = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    $display("[TB] frame starting at an even position");
    applyStimulus(0, 1, 0, 8'h55, 0, 8'hFB, 1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, frameA[i], 0, frameA[i], 0, (i % 2 == 1), 0);
    end
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hFD, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hF7, 1, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    $display("[TB] frame starting during idle, with error and double /R/");
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 1, 0, 8'h55, 0, 8'h50, 0, 0, 1);
    applyStimulus(0, 1, 0, 8'h55, 0, 8'hFB, 1, 1, 0);
    applyStimulus(0, 1, 0, 8'h55, 0, 8'h55, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'hD5, 0, 8'hD5, 0, 1, 0);
    applyStimulus(0, 1, 0, 8'h11, 0, 8'h11, 0, 0, 0);
    applyStimulus(0, 1, 1, 8'h22, 0, 8'hFE, 1, 1, 0);
    applyStimulus(0, 1, 0, 8'h33, 0, 8'h33, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h44, 0, 8'h44, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
    applyStimulus(0, 1, 0, 8'h99, 0, 8'hF7, 1, 1, 0);
    applyStimulus(0, 1, 0, 8'h99, 0, 8'hF7, 1, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    $display("[TB] config ordered sets");
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    curCfgWord = 16'hBEEF;
    applyStimulus(0, 1, 0, 8'h77, 1, 8'hB5, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hA0, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    curCfgWord = 16'h01A0;
    applyStimulus(0, 1, 0, 8'h77, 1, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h42, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hA0, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hB5, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hA0, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h42, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hA0, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hB5, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'hA0, 0, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1, 0, 8'h55, 0, 8'hFB, 1, 1, 0);
    applyStimulus(0, 1, 0, 8'h55, 0, 8'h55, 0, 0, 0);
    applyStimulus(1, 1, 0, 8'h55, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
